// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared phase encoding, default period lengths and game-length helper
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRELIM = 3'd1,
    ST_GAME   = 3'd2,
    ST_ANSWER = 3'd3,
    ST_POST   = 3'd4,
    ST_JUDGE  = 3'd5,
    ST_OVER   = 3'd6
  } phase_e;

  localparam int DEF_PRELIM_SECS    = 3;
  localparam int DEF_GAME_BASE_SECS = 10;
  localparam int DEF_ANSWER_SECS    = 8;
  localparam int DEF_POST_SECS      = 3;
  localparam int DEF_JUDGE_TIMEOUT  = 255;

  // Two extra seconds per level; the 8-bit seconds counter caps at 255.
  function automatic logic [7:0] game_len(input int base_secs, input logic [3:0] level);
    int sum;
    sum = base_secs + 2 * int'({28'd0, level});
    if (sum > 255) begin
      return 8'd255;
    end
    return 8'(sum);
  endfunction

endpackage

// File: rtl/sec_tick.sv
// rtl/sec_tick.sv - synchronises the 1 Hz input and emits a one-cycle tick per rising edge
module sec_tick (
  input  logic Clk100M,
  input  logic reset,
  input  logic Clk1Hz,
  output logic tick
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q,  prev_d;
  logic [1:0] warm_q,  warm_d;

  always_comb begin
    sync1_d = Clk1Hz;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    warm_d  = warm_q;
    if (warm_q != 2'd3) begin
      warm_d = warm_q + 2'd1;
    end
  end

  always_ff @(posedge Clk100M) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      warm_q  <= 2'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      warm_q  <= warm_d;
    end
  end

  // Edges are only trusted once the pipeline holds real samples, so a level
  // that was already high at reset release is not mistaken for a rising edge.
  assign tick = sync2_q & ~prev_q & (warm_q == 2'd3);

endmodule

// File: rtl/game_phase_sequencer.sv
// rtl/game_phase_sequencer.sv - sequences prelim/game/answer/post/judge periods of one level
module game_phase_sequencer
  import game_pkg::*;
#(
  parameter int PRELIM_SECS    = DEF_PRELIM_SECS,
  parameter int GAME_BASE_SECS = DEF_GAME_BASE_SECS,
  parameter int ANSWER_SECS    = DEF_ANSWER_SECS,
  parameter int POST_SECS      = DEF_POST_SECS,
  parameter int JUDGE_TIMEOUT  = DEF_JUDGE_TIMEOUT
) (
  input  logic       Clk100M,
  input  logic       reset,
  input  logic       Clk1Hz,
  input  logic       start,
  input  logic [3:0] curLevel,
  input  logic       incLevel,
  input  logic       lose,
  output logic       prelimSig,
  output logic       gameSig,
  output logic       answerSig,
  output logic       postSig,
  output logic       startGen,
  output logic       stopGen,
  output logic       stopCount,
  output logic       newLevel,
  output logic [2:0] phase,
  output logic [7:0] secsLeft,
  output logic       gameOver
);

  localparam logic [7:0]  PRELIM_LEN = 8'(PRELIM_SECS);
  localparam logic [7:0]  ANSWER_LEN = 8'(ANSWER_SECS);
  localparam logic [7:0]  POST_LEN   = 8'(POST_SECS);
  localparam logic [15:0] JUDGE_LAST = 16'(JUDGE_TIMEOUT - 1);

  logic tick;

  sec_tick u_sec_tick (
    .Clk100M (Clk100M),
    .reset   (reset),
    .Clk1Hz  (Clk1Hz),
    .tick    (tick)
  );

  phase_e      state_q, state_d;
  logic [7:0]  secs_q, secs_d;
  logic [15:0] judge_cnt_q, judge_cnt_d;
  logic        prelim_q, prelim_d;
  logic        game_q, game_d;
  logic        answer_q, answer_d;
  logic        post_q, post_d;
  logic        start_gen_q, start_gen_d;
  logic        stop_gen_q, stop_gen_d;
  logic        stop_count_q, stop_count_d;
  logic        new_level_q, new_level_d;
  logic        game_over_q, game_over_d;
  logic        expire;

  assign expire = tick && (secs_q == 8'd1);

  always_comb begin
    state_d      = state_q;
    secs_d       = secs_q;
    judge_cnt_d  = 16'd0;
    prelim_d     = 1'b0;
    game_d       = 1'b0;
    answer_d     = 1'b0;
    post_d       = 1'b0;
    start_gen_d  = 1'b0;
    stop_gen_d   = 1'b0;
    stop_count_d = 1'b0;
    new_level_d  = 1'b0;

    // Plain countdown; a period's expiry below overrides it with the next load.
    if (tick && (secs_q != 8'd0)) begin
      secs_d = secs_q - 8'd1;
    end

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d     = ST_PRELIM;
          secs_d      = PRELIM_LEN;
          prelim_d    = 1'b1;
          new_level_d = 1'b1;
        end
      end
      ST_PRELIM: begin
        if (expire) begin
          state_d     = ST_GAME;
          secs_d      = game_len(GAME_BASE_SECS, curLevel);
          game_d      = 1'b1;
          start_gen_d = 1'b1;
        end
      end
      ST_GAME: begin
        if (expire) begin
          state_d    = ST_ANSWER;
          secs_d     = ANSWER_LEN;
          answer_d   = 1'b1;
          stop_gen_d = 1'b1;
        end
      end
      ST_ANSWER: begin
        if (expire) begin
          state_d      = ST_POST;
          secs_d       = POST_LEN;
          post_d       = 1'b1;
          stop_count_d = 1'b1;
        end
      end
      ST_POST: begin
        if (expire) begin
          state_d = ST_JUDGE;
          secs_d  = 8'd0;
        end
      end
      ST_JUDGE: begin
        secs_d = 8'd0;
        if (lose) begin
          state_d = ST_OVER;
        end else if (incLevel) begin
          state_d     = ST_PRELIM;
          secs_d      = PRELIM_LEN;
          prelim_d    = 1'b1;
          new_level_d = 1'b1;
        end else if (judge_cnt_q == JUDGE_LAST) begin
          state_d = ST_OVER;
        end else begin
          judge_cnt_d = judge_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        secs_d  = 8'd0;
      end
    endcase

    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge Clk100M) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      secs_q       <= 8'd0;
      judge_cnt_q  <= 16'd0;
      prelim_q     <= 1'b0;
      game_q       <= 1'b0;
      answer_q     <= 1'b0;
      post_q       <= 1'b0;
      start_gen_q  <= 1'b0;
      stop_gen_q   <= 1'b0;
      stop_count_q <= 1'b0;
      new_level_q  <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      secs_q       <= secs_d;
      judge_cnt_q  <= judge_cnt_d;
      prelim_q     <= prelim_d;
      game_q       <= game_d;
      answer_q     <= answer_d;
      post_q       <= post_d;
      start_gen_q  <= start_gen_d;
      stop_gen_q   <= stop_gen_d;
      stop_count_q <= stop_count_d;
      new_level_q  <= new_level_d;
      game_over_q  <= game_over_d;
    end
  end

  assign prelimSig = prelim_q;
  assign gameSig   = game_q;
  assign answerSig = answer_q;
  assign postSig   = post_q;
  assign startGen  = start_gen_q;
  assign stopGen   = stop_gen_q;
  assign stopCount = stop_count_q;
  assign newLevel  = new_level_q;
  assign phase     = state_q;
  assign secsLeft  = secs_q;
  assign gameOver  = game_over_q;

endmodule

// File: doc/game_phase_sequencer.md
GAME_PHASE_SEQUENCER -- requirements
Module: game_phase_sequencer

Interface
REQ-001 SHALL have parameter PRELIM_SECS, default 3, prelim period length in seconds.
REQ-002 SHALL have parameter GAME_BASE_SECS, default 10, game period length at level 0.
REQ-003 SHALL have parameter ANSWER_SECS, default 8, answer period length in seconds.
REQ-004 SHALL have parameter POST_SECS, default 3, post period length in seconds.
REQ-005 SHALL have parameter JUDGE_TIMEOUT, default 255, Clk100M cycles to wait for a verdict.
REQ-006 Clk100M  in  1  sole clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 Clk1Hz  in  1  1 Hz square wave; a rising edge is one second tick.
REQ-009 start  in  1  level; starts a new game from IDLE or OVER.
REQ-010 curLevel  in  4  current level from the level controller.
REQ-011 incLevel  in  1  pulse; verdict pass.
REQ-012 lose  in  1  pulse; verdict fail.
REQ-013 prelimSig, gameSig, answerSig, postSig  out  1 each  one-cycle pulse on entry to each period.
REQ-014 startGen, stopGen, stopCount  out  1 each  one-cycle generator/counter control pulses.
REQ-015 newLevel  out  1  one-cycle pulse at the start of every level.
REQ-016 phase  out  3  encoded current state.
REQ-017 secsLeft  out  8  whole seconds remaining in the current timed period.
REQ-018 gameOver  out  1  level; high in OVER.

Function
REQ-019 States SHALL be IDLE, PRELIM, GAME, ANSWER, POST, JUDGE and OVER.
REQ-020 Tick SHALL be detected by a two-flop synchroniser on Clk1Hz followed by rising-edge detection, giving a one-cycle tick pulse.
REQ-021 IDLE/OVER with start=1 -> PRELIM on the next cycle; newLevel and prelimSig SHALL pulse in that entry cycle.
REQ-022 On entry to a timed state, secsLeft SHALL load its period length; each tick SHALL decrement it.
REQ-023 A tick with secsLeft=1 SHALL leave the state; a tick with secsLeft=0 SHALL NOT occur (no wrap).
REQ-024 Game length SHALL be GAME_BASE_SECS + 2*curLevel, with curLevel sampled on GAME entry and the sum saturating at 255.
REQ-025 PRELIM->GAME SHALL pulse gameSig and startGen together.
REQ-026 GAME->ANSWER SHALL pulse answerSig and stopGen together.
REQ-027 ANSWER->POST SHALL pulse postSig and stopCount together.
REQ-028 POST expiry -> JUDGE; secsLeft SHALL be 0 in JUDGE, IDLE and OVER.
REQ-029 JUDGE + incLevel -> PRELIM (newLevel and prelimSig pulse); JUDGE + lose -> OVER.
REQ-030 If incLevel and lose are both high in the same cycle, lose SHALL win.
REQ-031 incLevel and lose outside JUDGE SHALL be ignored.
REQ-032 JUDGE with no verdict for JUDGE_TIMEOUT cycles SHALL -> OVER.
REQ-033 start outside IDLE/OVER SHALL be ignored.
REQ-034 At most one period-entry pulse SHALL be high in any cycle.

Reset
REQ-035 reset SHALL force IDLE, secsLeft=0, all pulses 0, gameOver=0, clear the synchroniser flops to 0 and clear the judge timer, from any state.
REQ-036 The first cycle after reset deasserts SHALL NOT report a tick, even if Clk1Hz is high.

Structure
REQ-037 State encoding and the default period lengths SHALL live in the shared package game_pkg.
REQ-038 Tick synchronisation and edge detection SHALL be the sub-module sec_tick (Clk100M, reset, Clk1Hz -> tick).
REQ-039 All outputs SHALL be registered.

Verification
REQ-040 start=1 at curLevel=0 -> prelimSig and newLevel pulse; 3 ticks later gameSig and startGen pulse with secsLeft=10.
REQ-041 curLevel=3 at GAME entry -> secsLeft=16; stopGen pulses on the 16th tick.
REQ-042 In JUDGE, incLevel and lose asserted in the same cycle -> OVER, gameOver=1, no newLevel pulse.
REQ-043 In JUDGE, no verdict for 255 cycles -> OVER.
REQ-044 reset asserted mid-GAME with secsLeft=5 -> next cycle IDLE, secsLeft=0, no stopGen pulse.
REQ-045 Clk1Hz held high through reset release -> no decrement until its next rising edge.
